// File: rtl/opacc_ctrl.sv
// rtl/opacc_ctrl.sv - command sequencer feeding an outer-product accumulator (opacc)
// Optional: OPACC_CTRL_STORE_RECIRC_EN makes STORE recirculate co into ci (non-destructive read).
module opacc_ctrl #(
    parameter int nregs = 2,
    parameter int XLEN  = 8,
    parameter int vl    = 4,
    parameter int ml    = 4,
    localparam int AW   = (nregs > 1) ? $clog2(nregs) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [AW-1:0]            cmd_addr,
    input  logic [7:0]               cmd_len,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [vl-1:0][XLEN-1:0]  in_a,
    input  logic [vl-1:0][XLEN-1:0]  in_b,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [vl-1:0][XLEN-1:0]  out_data,

    output logic                     ab_valid,
    output logic                     c_valid,
    output logic [AW-1:0]            ci_addr,
    output logic [AW-1:0]            ab_addr,
    output logic [vl-1:0][XLEN-1:0]  ai,
    output logic [vl-1:0][XLEN-1:0]  bi,
    output logic [vl-1:0][XLEN-1:0]  ci,
    input  logic [vl-1:0][XLEN-1:0]  co,

    output logic                     busy
);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_MAC   = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_ZERO  = 2'd3;
    localparam logic [7:0] ML_N     = 8'(ml);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, ZERO} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic          live_q;
    logic          beat;
    logic [7:0]    last_n;

    // live_q keeps cmd_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (cmd_valid && cmd_ready) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        ab_valid  = 1'b0;
        c_valid   = 1'b0;
        ai        = '0;
        bi        = '0;
        ci        = '0;
        beat      = 1'b0;
        last_n    = (op_q == OP_MAC) ? len_q : ML_N;

        case (state_q)
            IDLE: begin
                cmd_ready = live_q;
                if (cmd_valid && live_q) begin
                    case (cmd_op)
                        OP_LOAD:  state_d = LOAD;
                        OP_MAC:   state_d = MAC;
                        OP_STORE: state_d = STORE;
                        OP_ZERO:  state_d = ZERO;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                c_valid  = in_valid;
                beat     = in_valid;
                if (in_valid) ci = in_a;
            end
            MAC: begin
                // zero-length MAC spends one cycle here and consumes nothing
                if (len_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    in_ready = 1'b1;
                    ab_valid = in_valid;
                    beat     = in_valid;
                    if (in_valid) begin
                        ai = in_a;
                        bi = in_b;
                    end
                end
            end
            STORE: begin
                out_valid = 1'b1;
                out_data  = co;
                c_valid   = out_ready;
                beat      = out_ready;
`ifdef OPACC_CTRL_STORE_RECIRC_EN
                if (out_ready) ci = co;
`else
                ci = '0;
`endif
            end
            ZERO: begin
                c_valid = 1'b1;
                beat    = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            if (cnt_q == last_n - 8'd1) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    assign ci_addr = addr_q;
    assign ab_addr = addr_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_opacc_ctrl.sv
// tb/tb_opacc_ctrl.sv - directed self-checking bench for opacc_ctrl with a behavioural opacc
module tb_opacc_ctrl;

    localparam int NREGS = 2;
    localparam int XLEN  = 8;
    localparam int VL    = 4;
    localparam int ML    = 4;
    localparam int AW    = 1;

    typedef logic [VL-1:0][XLEN-1:0] row_t;

    logic          clk, reset_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          in_valid, in_ready;
    row_t          in_a, in_b;
    logic          out_valid, out_ready;
    row_t          out_data;
    logic          ab_valid, c_valid;
    logic [AW-1:0] ci_addr, ab_addr;
    row_t          ai, bi, ci, co;
    logic          busy;

    opacc_ctrl #(.nregs(NREGS), .XLEN(XLEN), .vl(VL), .ml(ML)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ab_valid(ab_valid), .c_valid(c_valid), .ci_addr(ci_addr), .ab_addr(ab_addr),
        .ai(ai), .bi(bi), .ci(ci), .co(co), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural opacc: shift-in on c_valid, rank-1 accumulate on ab_valid
    row_t mreg [NREGS][ML];
    bit   m_init = 1'b0;
    int   cv_cnt = 0, av_cnt = 0, both_err = 0, idle_err = 0, gate_err = 0;

    assign co = mreg[ci_addr][ML-1];

    always @(posedge clk) begin
        if (!m_init) begin
            for (int r = 0; r < ML; r++) begin
                mreg[0][r] <= {VL{8'h5A}};
                mreg[1][r] <= {VL{8'hA5}};
            end
            m_init <= 1'b1;
        end else begin
            if (c_valid) begin
                for (int r = ML-1; r > 0; r--) mreg[ci_addr][r] <= mreg[ci_addr][r-1];
                mreg[ci_addr][0] <= ci;
            end
            if (ab_valid)
                for (int i = 0; i < ML; i++)
                    for (int j = 0; j < VL; j++)
                        mreg[ab_addr][i][j] <= mreg[ab_addr][i][j] + ai[i] * bi[j];
        end
        cv_cnt <= cv_cnt + int'(c_valid);
        av_cnt <= av_cnt + int'(ab_valid);
        if (ab_valid && c_valid) both_err <= both_err + 1;
        if (reset_n && !busy && (in_ready || out_valid)) idle_err <= idle_err + 1;
        if ((!c_valid && ci != '0) || (!ab_valid && (ai != '0 || bi != '0)) ||
            (!out_valid && out_data != '0)) gate_err <= gate_err + 1;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] len);
        int w = 0;
        while (!cmd_ready && w < 20) begin tick; w++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
        tick;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_len = 8'd0;
    endtask

    function automatic row_t mac_row(input int i);
        row_t r;
        for (int j = 0; j < VL; j++) r[j] = XLEN'(14*i*j + 12*i + 6*j + 8);
        return r;
    endfunction

    function automatic row_t load_row(input int i);
        row_t r;
        for (int j = 0; j < VL; j++) r[j] = XLEN'(i*j);
        return r;
    endfunction

    int   c0, bc, got_rows, cyc;
    bit   tog;
    row_t nrow [ML];

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_len = 8'd0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        #1 chk("rel_cmd_ready_pre_edge", cmd_ready, 0);
        tick;
        chk("rel_cmd_ready", cmd_ready, 1);

        // LOAD reg0 with r_i[j] = i*j, one stall after the second beat
        c0 = cv_cnt;
        issue(2'd0, 1'b0, 8'd0);
        for (int i = 0; i < ML; i++) begin
            in_valid = 1'b1; in_a = load_row(i);
            tick;
            if (i == 1) begin
                in_valid = 1'b0; in_a = {VL{8'hFF}};
                #1 chk("load_stall_cvalid", c_valid, 0);
                tick;
            end
        end
        in_valid = 1'b0; in_a = '0;
        chk("load_done_busy", busy, 0);
        chk("load_done_cmd_ready", cmd_ready, 1);
        chk("load_pulses", cv_cnt - c0, 4);
        for (int i = 0; i < ML; i++) chk($sformatf("load_row%0d", ML-1-i), mreg[0][ML-1-i], load_row(i));

        // ZERO reg1: exactly ml busy cycles
        c0 = cv_cnt;
        issue(2'd3, 1'b1, 8'd0);
        bc = 0;
        while (busy && bc < 20) begin bc++; tick; end
        chk("zero_busy_cycles", bc, 4);
        chk("zero_pulses", cv_cnt - c0, 4);
        for (int r = 0; r < ML; r++) chk($sformatf("zero_row%0d", r), mreg[1][r], 0);

        // MAC reg1 len=4, a[i]=i*k+1, b[j]=j*k+2, stall after k=2
        c0 = av_cnt;
        issue(2'd1, 1'b1, 8'd4);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < VL; i++) begin
                in_a[i] = XLEN'(i*k + 1);
                in_b[i] = XLEN'(i*k + 2);
            end
            tick;
            if (k == 2) begin
                in_valid = 1'b0;
                #1 chk("mac_stall_abvalid", ab_valid, 0);
                tick;
            end
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        chk("mac_done_busy", busy, 0);
        chk("mac_pulses", av_cnt - c0, 4);
        for (int i = 0; i < ML; i++) chk($sformatf("mac_row%0d", i), mreg[1][i], mac_row(i));

        // STORE reg1 with out_ready toggling 1,0,1,0...
        c0 = cv_cnt;
        issue(2'd2, 1'b1, 8'd0);
        got_rows = 0; cyc = 0; tog = 1'b1;
        while (busy && cyc < 40) begin
            out_ready = tog;
            #1;
            if (out_ready) begin
                chk("store_cvalid_hs", c_valid, 1);
                chk($sformatf("store_data%0d", got_rows), out_data, mac_row(ML-1-got_rows));
                got_rows++;
            end else begin
                chk("store_cvalid_stall", c_valid, 0);
                chk("store_out_valid", out_valid, 1);
            end
            tick;
            tog = !tog; cyc++;
        end
        out_ready = 1'b0;
        chk("store_rows", got_rows, 4);
        chk("store_pulses", cv_cnt - c0, 4);
        for (int i = 0; i < ML; i++)
`ifdef OPACC_CTRL_STORE_RECIRC_EN
            chk($sformatf("store_after_row%0d", i), mreg[1][i], mac_row(i));
`else
            chk($sformatf("store_after_row%0d", i), mreg[1][i], 0);
`endif

        // MAC with len=0: one busy cycle, no ab_valid
        c0 = av_cnt;
        issue(2'd1, 1'b1, 8'd0);
        chk("mac0_busy", busy, 1);
        tick;
        chk("mac0_idle", busy, 0);
        chk("mac0_cmd_ready", cmd_ready, 1);
        chk("mac0_pulses", av_cnt - c0, 0);

        // reset mid-LOAD after 2 beats, then a fresh LOAD
        c0 = cv_cnt;
        issue(2'd0, 1'b0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = {VL{XLEN'(8'h40 + i)}};
            tick;
        end
        in_a = {VL{8'h77}};
        #1 chk("pre_rst_cvalid", c_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cvalid", c_valid, 0);
        chk("mid_rst_ci", ci, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        in_valid = 1'b0; in_a = '0;
        tick;
        chk("mid_rst_pulses", cv_cnt - c0, 2);
        reset_n = 1'b1;
        tick;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < ML; i++) nrow[i] = {VL{XLEN'(8'h11 * (i + 1))}};
        c0 = cv_cnt;
        issue(2'd0, 1'b0, 8'd0);
        for (int i = 0; i < ML; i++) begin
            in_valid = 1'b1; in_a = nrow[i];
            tick;
            if (i == ML-2) chk("reload_busy_mid", busy, 1);
        end
        in_valid = 1'b0; in_a = '0;
        chk("reload_done_busy", busy, 0);
        chk("reload_pulses", cv_cnt - c0, 4);
        for (int i = 0; i < ML; i++) chk($sformatf("reload_row%0d", ML-1-i), mreg[0][ML-1-i], nrow[i]);

        chk("ab_c_exclusive", both_err, 0);
        chk("idle_quiet", idle_err, 0);
        chk("data_gating", gate_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
